muldiv_sched: RTL and testbench

//  Multi-cycle multiply/divide sequencer owning the HI/LO registers for the 5-stage pipeline.

---
 rtl/muldiv_sched_pkg.sv | 31 +++
 rtl/muldiv_arith.sv | 74 +++++++
 rtl/muldiv_sched.sv | 123 ++++++++++++
 tb/tb_muldiv_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sched_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//  - op encodings as presented on the E-stage op field
//  - default busy-cycle counts
//  - sequencer state codes
package muldiv_sched_pkg;

    // Operation encodings (op[1] selects divide, op[0] selects unsigned)
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Default operand width and busy durations
    localparam int unsigned MD_WIDTH_DEF       = 32;
    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    // Sequencer states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Width of a down-counter able to hold (cycles - 1), never less than 1 bit
    function automatic int unsigned md_cnt_width(input int unsigned cycles);
        int unsigned w;
        w = (cycles > 1) ? $clog2(cycles) : 1;
        return w;
    endfunction

endpackage

// File: rtl/muldiv_arith.sv
// Combinational multiply/divide datapath.
//  Produces the full 2*WIDTH result for the selected op, packed as {hi, lo}.
//  Ports:
//   op          in   2        operation select (mult/multu/div/divu)
//   rs_val      in   WIDTH    multiplicand / dividend
//   rt_val      in   WIDTH    multiplier / divisor
//   result_c    out  2*WIDTH  {hi, lo}: product, or {remainder, quotient}
//   div_zero_c  out  1        divide op with zero divisor (result must not commit)
module muldiv_arith
    import muldiv_sched_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH_DEF
) (
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   rs_val,
    input  logic [WIDTH-1:0]   rt_val,
    output logic [2*WIDTH-1:0] result_c,
    output logic               div_zero_c
);

    localparam int unsigned DW = 2 * WIDTH;

    logic [DW-1:0]    mul_a;
    logic [DW-1:0]    mul_b;
    logic [DW-1:0]    product;
    logic             signed_div;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] safe_b;
    logic [WIDTH-1:0] quo_mag;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    // Multiply: extend both operands to 2*WIDTH (sign or zero) and keep the
    // low 2*WIDTH bits; two's complement makes this the exact signed product.
    always_comb begin
        mul_a   = op[0] ? {{WIDTH{1'b0}}, rs_val} : {{WIDTH{rs_val[WIDTH-1]}}, rs_val};
        mul_b   = op[0] ? {{WIDTH{1'b0}}, rt_val} : {{WIDTH{rt_val[WIDTH-1]}}, rt_val};
        product = mul_a * mul_b;
    end

    // Divide: unsigned divide on magnitudes, then restore signs. The most
    // negative dividend over -1 falls out naturally as quotient 0x80..0, rem 0.
    always_comb begin
        signed_div = (op == MD_DIV);
        neg_a      = signed_div & rs_val[WIDTH-1];
        neg_b      = signed_div & rt_val[WIDTH-1];
        mag_a      = neg_a ? -rs_val : rs_val;
        mag_b      = neg_b ? -rt_val : rt_val;
        // Substitute divisor 1 for zero so the divider never sees x; the
        // zero flag suppresses the commit anyway.
        safe_b     = (mag_b == '0) ? WIDTH'(1) : mag_b;
        quo_mag    = mag_a / safe_b;
        rem_mag    = mag_a % safe_b;
        quotient   = (neg_a ^ neg_b) ? -quo_mag : quo_mag;
        remainder  = neg_a ? -rem_mag : rem_mag;
    end

    // Result select
    always_comb begin
        result_c   = '0;
        div_zero_c = 1'b0;
        if (op[1]) begin
            result_c   = {remainder, quotient};
            div_zero_c = (rt_val == '0);
        end else begin
            result_c   = product;
        end
    end

endmodule

// File: rtl/muldiv_sched.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
//  An E-stage issue latches the full result immediately, then holds busy for a
//  fixed cycle count before committing it to HI/LO, mimicking an iterative unit.
//  Ports:
//   clk        in   1      pipeline clock, rising edge
//   reset      in   1      asynchronous, active-high
//   start      in   1      mult/div issue strobe
//   op         in   2      operation, sampled with start
//   rs_val     in   WIDTH  rs operand (dividend / multiplicand)
//   rt_val     in   WIDTH  rt operand (divisor / multiplier)
//   hi_we      in   1      mthi write strobe
//   lo_we      in   1      mtlo write strobe
//   wdata      in   WIDTH  mthi/mtlo data
//   md_use_D   in   1      D-stage instruction uses the mult/div unit or HI/LO
//   busy       out  1      operation in progress (registered)
//   stall_req  out  1      D-stage stall request (combinational)
//   hi         out  WIDTH  HI register
//   lo         out  WIDTH  LO register
module muldiv_sched
    import muldiv_sched_pkg::*;
#(
    parameter int unsigned WIDTH       = MD_WIDTH_DEF,
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             md_use_D,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = md_cnt_width(MAX_CYCLES);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e          state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] pend;
    logic               pend_zero;
    logic [2*WIDTH-1:0] arith_result_c;
    logic               arith_div_zero_c;

    muldiv_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .result_c   (arith_result_c),
        .div_zero_c (arith_div_zero_c)
    );

    // Stall covers the issue cycle too, so a dependent D-stage instruction
    // directly behind a mult/div waits for the whole operation.
    assign stall_req = md_use_D & (start | busy);

    // Sequencer: IDLE accepts an issue or mthi/mtlo; RUN counts down and commits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            count     <= '0;
            pend      <= '0;
            pend_zero <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Issue wins over any simultaneous mthi/mtlo
                        pend      <= arith_result_c;
                        pend_zero <= arith_div_zero_c;
                        count     <= op[1] ? DIV_LOAD : MULT_LOAD;
                        state     <= ST_RUN;
                        busy      <= 1'b1;
                    end else begin
                        if (hi_we) begin
                            hi <= wdata;
                        end
                        if (lo_we) begin
                            lo <= wdata;
                        end
                    end
                end
                ST_RUN: begin
                    if (count == '0) begin
                        // Divide by zero leaves HI/LO untouched
                        if (!pend_zero) begin
                            hi <= pend[2*WIDTH-1:WIDTH];
                            lo <= pend[WIDTH-1:0];
                        end
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // The hazard unit must hold off any new issue or HI/LO write while busy
    a_no_access_while_busy: assert property (
        @(posedge clk) disable iff (reset) busy |-> !(start || hi_we || lo_we)
    ) else $error("muldiv_sched: start/hi_we/lo_we asserted while busy");

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: scoreboard of expected {hi,lo} pushed
// at issue and popped when busy drops.
module tb_muldiv_sched;

    localparam int unsigned W      = 32;
    localparam int unsigned N_MULT = 5;
    localparam int unsigned N_DIV  = 10;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         md_use_D;
    logic         busy;
    logic         stall_req;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks;
    int errors;
    logic [63:0] sb_q[$];
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    muldiv_sched #(
        .WIDTH       (W),
        .MULT_CYCLES (N_MULT),
        .DIV_CYCLES  (N_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .md_use_D  (md_use_D),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: 64-bit integer arithmetic, independent of the RTL datapath
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        res = cur;
        case (o)
            2'b00: res = 64'(sa * sb);
            2'b01: res = ua * ub;
            2'b10: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            default: if (b != 0) begin
                res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Issue one op, track busy/stall every cycle, then pop and compare HI/LO
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic use_d, input logic with_wr, input string name);
        int n;
        int cycles;
        logic [63:0] exp;
        n = o[1] ? N_DIV : N_MULT;
        op = o; rs_val = a; rt_val = b; start = 1'b1; md_use_D = use_d;
        hi_we = with_wr; lo_we = with_wr; wdata = 32'hDEAD_BEEF;
        sb_q.push_back(model(o, a, b, {m_hi, m_lo}));
        #1;
        checks++;
        if (stall_req !== use_d) begin
            errors++;
            $display("FAIL %s issue stall_req: got %b want %b", name, stall_req, use_d);
        end
        step();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            checks++;
            if (stall_req !== use_d) begin
                errors++;
                $display("FAIL %s busy stall_req cyc %0d: got %b want %b", name, cycles, stall_req, use_d);
            end
            step();
            cycles++;
        end
        checks++;
        if (cycles != n) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, cycles, n);
        end
        checks++;
        if (stall_req !== 1'b0) begin
            errors++;
            $display("FAIL %s post stall_req: got %b want 0", name, stall_req);
        end
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            exp = sb_q.pop_front();
            checks++;
            if ({hi, lo} !== exp) begin
                errors++;
                $display("FAIL %s hilo: got %h_%h want %h_%h", name, hi, lo, exp[63:32], exp[31:0]);
            end
            m_hi = exp[63:32];
            m_lo = exp[31:0];
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0; md_use_D = 1'b1;
        step(); step();
        checks++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0 || stall_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b hi=%h lo=%h stall=%b want 0/0/0/0", busy, hi, lo, stall_req);
        end
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        step();
    endtask

    task automatic test_mult();
        run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, "mult_neg2x3");
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
            errors++;
            $display("FAIL mult_const: got %h_%h want ffffffff_fffffffa", hi, lo);
        end
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, "multu_max");
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
            errors++;
            $display("FAIL multu_const: got %h_%h want fffffffe_00000001", hi, lo);
        end
    endtask

    task automatic test_div();
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "div_neg7by2");
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            errors++;
            $display("FAIL div_const: got %h_%h want ffffffff_fffffffd", hi, lo);
        end
        run_op(2'b11, 32'd7, 32'd0, 1'b1, 1'b0, "divu_by0");
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            errors++;
            $display("FAIL divu_by0_unchanged: got %h_%h want ffffffff_fffffffd", hi, lo);
        end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_overflow");
        checks++;
        if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
            errors++;
            $display("FAIL div_overflow_const: got %h_%h want 00000000_80000000", hi, lo);
        end
    endtask

    task automatic test_mthi_mtlo();
        hi_we = 1'b1; wdata = 32'h0000_1234; md_use_D = 1'b0;
        step();
        hi_we = 1'b0;
        checks++;
        if (hi !== 32'h1234 || lo !== m_lo || busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi: got hi=%h lo=%h busy=%b want hi=00001234 lo=%h busy=0", hi, lo, busy, m_lo);
        end
        m_hi = 32'h1234;
        lo_we = 1'b1; wdata = 32'hCAFE_0001;
        step();
        lo_we = 1'b0;
        checks++;
        if (lo !== 32'hCAFE_0001 || hi !== m_hi || busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: got hi=%h lo=%h busy=%b want hi=%h lo=cafe0001 busy=0", hi, lo, busy, m_hi);
        end
        m_lo = 32'hCAFE_0001;
    endtask

    task automatic test_start_with_write();
        // Zero divisor keeps HI/LO, so any leaked mthi/mtlo would be visible
        run_op(2'b11, 32'd99, 32'd0, 1'b1, 1'b1, "start_wins");
        checks++;
        if (hi !== 32'h1234 || lo !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL start_drops_write: got %h_%h want 00001234_cafe0001", hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 8; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 9));
            if (i == 5) b = 32'd0;
            run_op(o, a, b, 1'(i % 2), 1'b0, $sformatf("b2b_%0d", i));
        end
    endtask

    task automatic test_reset_mid_run();
        op = 2'b10; rs_val = 32'd1000; rt_val = 32'd7; start = 1'b1; md_use_D = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0 || stall_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b hi=%h lo=%h stall=%b want 0/0/0/0", busy, hi, lo, stall_req);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 14; i++) step();
        checks++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
            errors++;
            $display("FAIL no_commit_after_reset: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        end
        m_hi = '0; m_lo = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_start_with_write();
        test_back_to_back();
        test_reset_mid_run();
        run_op(2'b00, 32'd12345, 32'hFFFF_FF00, 1'b1, 1'b0, "after_reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
